// File: rtl/dff_arb_pkg.sv
// Shared types, defaults and helpers for the round-robin shared-register arbiter.
package dff_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t DONE = 2'd2;

  // First set request after 'last', wrapping modulo n (n <= 16).
  function automatic logic [3:0] rr_next(input logic [15:0] req, input logic [3:0] last,
                                         input int unsigned n);
    logic [3:0]  win;
    logic        found;
    int unsigned idx;
    win   = 4'd0;
    found = 1'b0;
    for (int unsigned k = 32'd1; k <= 32'd16; k++) begin
      idx = (32'(last) + k) % n;
      if (!found && (k <= n) && req[idx[3:0]]) begin
        win   = idx[3:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic even_par(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/dff_share_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: picks the next requester after last_winner.
import dff_arb_pkg::*;

module rr_pick #(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_winner,
  output logic [IDW-1:0]  winner,
  output logic            valid
);

  assign winner = IDW'(rr_next(16'(req), 4'(last_winner), NREQ));
  assign valid  = |req;

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin write arbiter owning one shared WIDTH-bit register.
// Optional DFF_ARB_PARITY_EN adds q_par, the even parity of the loaded value.
import dff_arb_pkg::*;

module dff_share_arbiter #(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       ack,
  output logic [IDW-1:0]        gnt_id,
  output logic                  busy,
  output logic [WIDTH-1:0]      q
`ifdef DFF_ARB_PARITY_EN
  ,
  output logic                  q_par
`endif
);

  state_t           state_r, next_state_s;
  logic [IDW-1:0]   gnt_id_r, last_winner_r, pick_id_s;
  logic             pick_valid_s;
  logic [WIDTH-1:0] q_r, load_data_s;
  logic [NREQ-1:0]  ack_r, ack_next_s;
  logic             busy_r;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req        (req),
    .last_winner(last_winner_r),
    .winner     (pick_id_s),
    .valid      (pick_valid_s)
  );

  // Next-state logic; req is only looked at while idle.
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) next_state_s = LOAD;
        else              next_state_s = IDLE;
      end
      LOAD:    next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Data mux for the granted requester's slice.
  always_comb begin
    load_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      load_data_s = (gnt_id_r == IDW'(i)) ? din[i*WIDTH +: WIDTH] : load_data_s;
    end
  end

  // Ack is registered one cycle ahead so it is high exactly while in DONE.
  always_comb begin
    if (next_state_s == DONE) ack_next_s = {{(NREQ-1){1'b0}}, 1'b1} << gnt_id_r;
    else                      ack_next_s = {NREQ{1'b0}};
  end

  // FSM, grant bookkeeping and the shared register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      gnt_id_r      <= {IDW{1'b0}};
      last_winner_r <= IDW'(NREQ-1);
      q_r           <= {WIDTH{1'b0}};
      ack_r         <= {NREQ{1'b0}};
      busy_r        <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ack_r   <= ack_next_s;
      busy_r  <= (next_state_s != IDLE);
      case (state_r)
        IDLE:    if (pick_valid_s) gnt_id_r <= pick_id_s;
        LOAD:    q_r <= load_data_s;
        DONE:    last_winner_r <= gnt_id_r;
        default: ;
      endcase
    end
  end

  assign ack    = ack_r;
  assign gnt_id = gnt_id_r;
  assign busy   = busy_r;
  assign q      = q_r;

`ifdef DFF_ARB_PARITY_EN
  logic q_par_r;

  // Parity captured in the same edge as the data it covers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                q_par_r <= 1'b0;
    else if (state_r == LOAD)  q_par_r <= even_par(64'(load_data_s));
  end

  assign q_par = q_par_r;
`endif

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Self-checking bench for dff_share_arbiter (NREQ=4, WIDTH=8).
module tb_dff_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  ack;
  logic [1:0]  gnt_id;
  logic        busy;
  logic [7:0]  q;
`ifdef DFF_ARB_PARITY_EN
  logic        q_par;
`endif

  dff_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .din   (din),
    .ack   (ack),
    .gnt_id(gnt_id),
    .busy  (busy),
    .q     (q)
`ifdef DFF_ARB_PARITY_EN
    ,
    .q_par (q_par)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Transaction-level reference: edge number of the latest grant plus winner history.
  int         m_t       = 0;
  int         m_grant_t = -100;
  int         m_win     = 0;
  int         m_last    = NREQ - 1;
  logic [7:0] m_q       = 8'h00;

  typedef struct {
    logic [3:0] req;
    logic [7:0] data;
    logic [1:0] exp_gnt;
  } vec_t;

  vec_t vecs[8];
  int   ack_order[$];
  int   exp_order[5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_search(input logic [3:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_grant_t = -100;
    m_win     = 0;
    m_last    = NREQ - 1;
    m_q       = 8'h00;
  endtask

  // One clock edge: update the reference, then compare on the falling edge.
  task automatic step();
    logic [31:0] exp_ack;
    @(posedge clk);
    m_t++;
    if (!rst_n) model_reset();
    else if (m_t >= m_grant_t + 3 && req != 4'd0) begin
      m_win     = rr_search(req, m_last);
      m_grant_t = m_t;
    end else if (m_t == m_grant_t + 1) m_q = din[m_win*8 +: 8];
    else if (m_t == m_grant_t + 2) m_last = m_win;
    @(negedge clk);
    exp_ack = (m_t == m_grant_t + 1) ? (32'd1 << m_win) : 32'd0;
    chk("model_q",    q,      m_q);
    chk("model_ack",  ack,    exp_ack);
    chk("model_busy", busy,   (m_t <= m_grant_t + 1) ? 32'd1 : 32'd0);
    chk("model_gnt",  gnt_id, m_win);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_q"},    q,      32'd0);
    chk({tag, "_ack"},  ack,    32'd0);
    chk({tag, "_busy"}, busy,   32'd0);
    chk({tag, "_gnt"},  gnt_id, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_outputs("rst");
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{4'b0100, 8'hA5, 2'd2};
    vecs[1] = '{4'b1001, 8'h3C, 2'd3};
    vecs[2] = '{4'b1001, 8'h11, 2'd0};
    vecs[3] = '{4'b1001, 8'h77, 2'd3};
    vecs[4] = '{4'b0011, 8'h5A, 2'd0};
    vecs[5] = '{4'b0011, 8'hC3, 2'd1};
    vecs[6] = '{4'b0001, 8'hFF, 2'd0};
    vecs[7] = '{4'b0110, 8'h00, 2'd1};

    // Reset held with all requests asserted: nothing may move.
    rst_n = 1'b0;
    req   = 4'hF;
    din   = 32'h44332211;
    #1;
    chk_reset_outputs("rst_init");
    for (int i = 0; i < 3; i++) step();
    chk_reset_outputs("rst_hold");
    req   = 4'h0;
    rst_n = 1'b1;
    step();

    // Table of single transactions from idle, starting with last_winner = 3.
    for (int v = 0; v < 8; v++) begin
      req = vecs[v].req;
      din = {4{~vecs[v].data}};
      din[vecs[v].exp_gnt*8 +: 8] = vecs[v].data;
      step();
      chk("tbl_gnt",       gnt_id, vecs[v].exp_gnt);
      chk("tbl_busy_load", busy,   32'd1);
      chk("tbl_ack_load",  ack,    32'd0);
      step();
      chk("tbl_q",         q,      vecs[v].data);
      chk("tbl_ack_done",  ack,    32'd1 << vecs[v].exp_gnt);
      chk("tbl_busy_done", busy,   32'd1);
      req = 4'h0;
      step();
      chk("tbl_ack_idle",  ack,    32'd0);
      chk("tbl_busy_idle", busy,   32'd0);
    end

    // All requests held: strict rotation, one ack every 3 cycles.
    do_reset();
    req = 4'hF;
    din = 32'h44332211;
    for (int c = 0; c < 15; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) if (ack[i]) ack_order.push_back(i);
    end
    chk("rot_count", ack_order.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < ack_order.size()) chk("rot_order", ack_order[i], exp_order[i]);
    end
    req = 4'h0;
    step();
    step();

    // Request dropped during LOAD still completes.
    req = 4'b0010;
    din = 32'h00009B00;
    step();
    req = 4'h0;
    step();
    chk("drop_q",   q,   32'h9B);
    chk("drop_ack", ack, 32'b0010);
    step();

    // Reset in DONE clears immediately.
    req = 4'b0100;
    din = 32'h00E70000;
    step();
    step();
    chk("pre_rst_ack", ack, 32'b0100);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_outputs("rst_done");
    step();
    req   = 4'h0;
    rst_n = 1'b1;
    step();

    // Randomised traffic with occasional resets, checked against the reference.
    for (int c = 0; c < 600; c++) begin
      req = 4'($urandom_range(0, 15));
      din = $urandom();
      if ($urandom_range(0, 59) == 0) do_reset();
      else step();
    end

`ifdef DFF_ARB_PARITY_EN
    req = 4'h0;
    step();
    step();
    step();
    req = 4'b0001;
    din = 32'h00000007;
    step();
    step();
    req = 4'h0;
    step();
    chk("par_07", q_par, 32'd1);
    req = 4'b0001;
    din = 32'h00000003;
    step();
    step();
    req = 4'h0;
    step();
    chk("par_03", q_par, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
